// File: rtl/tug_pkg.sv
// Shared types and widths for the tug-of-war playfield.
package tug_pkg;

    typedef enum logic [1:0] {NONE, LEFT, RIGHT} winner_t;
    typedef enum logic [1:0] {PLAY, POINT, OVER} state_t;

    localparam int SCORE_W = 4;

endpackage

// File: rtl/press_edge.sv
// Turns a synchronised key level into a single-cycle press strobe on its rising edge.
module press_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic prev_q;

    // History resets high so a key already held at reset never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= key;
        end
    end

    assign press = key & ~prev_q;

endmodule

// File: rtl/tug_field.sv
// Two-player tug-of-war: presses pull a single light toward each player's end to score.
module tug_field
    import tug_pkg::*;
#(
    parameter int N_LIGHTS     = 9,
    parameter int WIN_SCORE    = 3,
    parameter int PAUSE_CYCLES = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                L,
    input  logic                R,
    output logic [N_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r,
    output winner_t             point_winner,
    output logic                game_over
);

    localparam int PW = $clog2(N_LIGHTS);
    localparam int CW = $clog2(PAUSE_CYCLES + 1);

    localparam logic [PW-1:0]      CENTER     = PW'(N_LIGHTS / 2);
    localparam logic [PW-1:0]      MAX_POS    = PW'(N_LIGHTS - 1);
    localparam logic [CW-1:0]      PAUSE_LOAD = CW'(PAUSE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    logic pressL;
    logic pressR;

    state_t              state_q, state_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SCORE_W-1:0]  scoreL_q, scoreL_d;
    logic [SCORE_W-1:0]  scoreR_q, scoreR_d;
    winner_t             winner_q, winner_d;

    press_edge uPressL (.clk(clk), .reset(reset), .key(L), .press(pressL));
    press_edge uPressR (.clk(clk), .reset(reset), .key(R), .press(pressR));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLAY;
            pos_q    <= CENTER;
            cnt_q    <= '0;
            scoreL_q <= '0;
            scoreR_q <= '0;
            winner_q <= NONE;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            scoreL_q <= scoreL_d;
            scoreR_q <= scoreR_d;
            winner_q <= winner_d;
        end
    end

    // Presses outside PLAY fall through untouched; the press detectors keep tracking anyway.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        scoreL_d = scoreL_q;
        scoreR_d = scoreR_q;
        winner_d = winner_q;
        case (state_q)
            PLAY: begin
                if (pressL && !pressR) begin
                    if (pos_q == MAX_POS) begin
                        scoreL_d = scoreL_q + SCORE_W'(1);
                        winner_d = LEFT;
                        if (scoreL_d == WIN) begin
                            state_d = OVER;
                        end else begin
                            state_d = POINT;
                            cnt_d   = PAUSE_LOAD;
                        end
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end else if (pressR && !pressL) begin
                    if (pos_q == '0) begin
                        scoreR_d = scoreR_q + SCORE_W'(1);
                        winner_d = RIGHT;
                        if (scoreR_d == WIN) begin
                            state_d = OVER;
                        end else begin
                            state_d = POINT;
                            cnt_d   = PAUSE_LOAD;
                        end
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end
            end
            POINT: begin
                if (cnt_q == '0) begin
                    state_d = PLAY;
                    pos_d   = CENTER;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            OVER: begin
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    always_comb begin
        lights = '0;
        if (state_q == PLAY) begin
            lights[pos_q] = 1'b1;
        end
    end

    assign score_l      = scoreL_q;
    assign score_r      = scoreR_q;
    assign point_winner = winner_q;
    assign game_over    = (state_q == OVER);

endmodule

// File: tb/tb_tug_field.sv
// Self-checking bench for tug_field: directed vector table, corner sequences, then random play vs a model.
module tb_tug_field;
    import tug_pkg::*;

    localparam int NL     = 5;
    localparam int WS     = 2;
    localparam int PC     = 4;
    localparam int CENTER = NL / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          L;
    logic          R;
    logic [NL-1:0] lights;
    logic [3:0]    score_l;
    logic [3:0]    score_r;
    winner_t       point_winner;
    logic          game_over;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic          l;
        logic          r;
        logic [NL-1:0] lights;
        int            sl;
        int            sr;
        int            win;
        logic          over;
    } vec_t;

    vec_t vecs[$];

    // Reference model: mode 0 = playing, 1 = paused, 2 = match over.
    int mPos, mScoreL, mScoreR, mWinner, mMode, mPauseLeft;
    bit mPrevL, mPrevR;

    tug_field #(.N_LIGHTS(NL), .WIN_SCORE(WS), .PAUSE_CYCLES(PC)) dut (
        .clk(clk), .reset(reset), .L(L), .R(R), .lights(lights),
        .score_l(score_l), .score_r(score_r), .point_winner(point_winner), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        mPos = CENTER; mScoreL = 0; mScoreR = 0; mWinner = int'(NONE);
        mMode = 0; mPauseLeft = 0; mPrevL = 1'b1; mPrevR = 1'b1;
    endfunction

    function automatic void award(input bit left);
        if (left) begin
            mScoreL++; mWinner = int'(LEFT);
        end else begin
            mScoreR++; mWinner = int'(RIGHT);
        end
        if (mScoreL == WS || mScoreR == WS) mMode = 2;
        else begin
            mMode = 1; mPauseLeft = PC;
        end
    endfunction

    function automatic void modelStep(input bit l, input bit r);
        bit pl, pr;
        pl = l && !mPrevL;
        pr = r && !mPrevR;
        mPrevL = l;
        mPrevR = r;
        if (mMode == 0) begin
            if (pl && !pr) begin
                if (mPos == NL - 1) award(1'b1);
                else mPos++;
            end else if (pr && !pl) begin
                if (mPos == 0) award(1'b0);
                else mPos--;
            end
        end else if (mMode == 1) begin
            mPauseLeft--;
            if (mPauseLeft == 0) begin
                mMode = 0; mPos = CENTER;
            end
        end
    endfunction

    function automatic logic [NL-1:0] modelLights();
        logic [NL-1:0] v;
        v = '0;
        if (mMode == 0) v[mPos] = 1'b1;
        return v;
    endfunction

    function automatic void addVec(input logic l, input logic r, input logic [NL-1:0] lt,
                                   input int sl, input int sr, input int win, input logic over);
        vec_t v;
        v.l = l; v.r = r; v.lights = lt; v.sl = sl; v.sr = sr; v.win = win; v.over = over;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic l, input logic r);
        @(negedge clk);
        reset = 1'b0; L = l; R = r;
        @(posedge clk);
        #1;
        modelStep(l, r);
    endtask

    task automatic doReset(input logic l, input logic r);
        @(negedge clk);
        reset = 1'b1; L = l; R = r;
        @(posedge clk);
        #1;
        modelReset();
    endtask

    task automatic checkOutput(input string name, input logic [NL-1:0] expLights, input int expSl,
                               input int expSr, input int expWin, input logic expOver);
        vectors++;
        if (lights !== expLights) begin
            miscompares++;
            $display("[TB] FAIL %s lights: got %b want %b", name, lights, expLights);
        end
        vectors++;
        if (score_l !== 4'(expSl) || score_r !== 4'(expSr) || int'(point_winner) != expWin
            || game_over !== expOver) begin
            miscompares++;
            $display("[TB] FAIL %s status: got l=%0d r=%0d win=%0d over=%b want l=%0d r=%0d win=%0d over=%b",
                     name, score_l, score_r, int'(point_winner), game_over, expSl, expSr, expWin, expOver);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, modelLights(), mScoreL, mScoreR, mWinner, logic'(mMode == 2));
    endtask

    initial begin
        int n, w, lw;
        n = int'(NONE); w = int'(LEFT); lw = int'(RIGHT);
        reset = 1'b1; L = 1'b0; R = 1'b0;

        // Idle first: reset leaves key history high.
        addVec(0, 0, 5'b00100, 0, 0, n, 0);
        addVec(1, 0, 5'b01000, 0, 0, n, 0);
        addVec(1, 0, 5'b01000, 0, 0, n, 0);
        addVec(1, 0, 5'b01000, 0, 0, n, 0);
        addVec(0, 0, 5'b01000, 0, 0, n, 0);
        addVec(0, 1, 5'b00100, 0, 0, n, 0);
        addVec(0, 0, 5'b00100, 0, 0, n, 0);
        addVec(0, 1, 5'b00010, 0, 0, n, 0);
        addVec(0, 0, 5'b00010, 0, 0, n, 0);
        addVec(1, 1, 5'b00010, 0, 0, n, 0);
        addVec(0, 0, 5'b00010, 0, 0, n, 0);
        addVec(1, 0, 5'b00100, 0, 0, n, 0);
        addVec(0, 0, 5'b00100, 0, 0, n, 0);
        addVec(1, 0, 5'b01000, 0, 0, n, 0);
        addVec(0, 0, 5'b01000, 0, 0, n, 0);
        addVec(1, 0, 5'b10000, 0, 0, n, 0);
        addVec(0, 0, 5'b10000, 0, 0, n, 0);
        addVec(1, 0, 5'b00000, 1, 0, w, 0);
        addVec(0, 1, 5'b00000, 1, 0, w, 0);
        addVec(0, 1, 5'b00000, 1, 0, w, 0);
        addVec(0, 1, 5'b00000, 1, 0, w, 0);
        addVec(0, 1, 5'b00100, 1, 0, w, 0);
        addVec(0, 1, 5'b00100, 1, 0, w, 0);
        addVec(0, 0, 5'b00100, 1, 0, w, 0);
        addVec(0, 1, 5'b00010, 1, 0, w, 0);
        addVec(0, 0, 5'b00010, 1, 0, w, 0);
        addVec(1, 0, 5'b00100, 1, 0, w, 0);
        addVec(0, 0, 5'b00100, 1, 0, w, 0);
        addVec(1, 0, 5'b01000, 1, 0, w, 0);
        addVec(0, 0, 5'b01000, 1, 0, w, 0);
        addVec(1, 0, 5'b10000, 1, 0, w, 0);
        addVec(0, 0, 5'b10000, 1, 0, w, 0);
        addVec(1, 0, 5'b00000, 2, 0, w, 1);
        addVec(0, 0, 5'b00000, 2, 0, w, 1);
        addVec(1, 1, 5'b00000, 2, 0, w, 1);
        addVec(0, 1, 5'b00000, 2, 0, w, 1);
        addVec(0, 0, 5'b00000, 2, 0, w, 1);

        doReset(0, 0);
        checkOutput("reset", 5'b00100, 0, 0, n, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].l, vecs[i].r);
            checkOutput($sformatf("vec%0d", i), vecs[i].lights, vecs[i].sl, vecs[i].sr,
                        vecs[i].win, vecs[i].over);
        end

        doReset(0, 0);
        checkOutput("reset_after_over", 5'b00100, 0, 0, n, 1'b0);

        // Right scores a point, then reset lands in the middle of the pause.
        applyStimulus(0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1);
            checkModel("walk_right");
            applyStimulus(0, 0);
        end
        checkOutput("right_point", 5'b00000, 0, 1, lw, 1'b0);
        applyStimulus(0, 0);
        checkModel("mid_pause");
        doReset(0, 0);
        checkOutput("reset_mid_point", 5'b00100, 0, 0, n, 1'b0);

        // Key held through reset must not register as a press.
        doReset(1, 0);
        applyStimulus(1, 0);
        checkOutput("held_through_reset", 5'b00100, 0, 0, n, 1'b0);
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        checkOutput("press_after_release", 5'b01000, 0, 0, n, 1'b0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            checkModel("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
